// File: rtl/myproject_arith_pkg.sv
// Shared arithmetic definitions for the sequential signed divider family.
// Holds the divider FSM state type, default operand widths and the
// default-width quotient saturation constants.
package myproject_arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } sdiv_state_e;

  localparam int DIN0_W = 26;  // signed dividend width
  localparam int DIN1_W = 13;  // unsigned divisor width
  localparam int DOUT_W = 16;  // signed quotient width

  // Saturation values for a DOUT_W-bit signed quotient.
  localparam logic [DOUT_W-1:0] QMAX = 16'h7FFF;
  localparam logic [DOUT_W-1:0] QMIN = 16'h8000;

endpackage

// File: rtl/myproject_sdiv_26s_13ns_16_seq_if.sv
// Request/result bundle for the sequential signed divider.
// master drives start/din0/din1; slave returns ready/done/dout/rout/ovf/dz.
// No flow control beyond start/ready: start is only taken while ready is high.
interface myproject_sdiv_26s_13ns_16_seq_if
  import myproject_arith_pkg::*;
#(
  parameter int din0_WIDTH = DIN0_W,
  parameter int din1_WIDTH = DIN1_W,
  parameter int dout_WIDTH = DOUT_W
);

  logic                  start;
  logic [din0_WIDTH-1:0] din0;
  logic [din1_WIDTH-1:0] din1;
  logic                  ready;
  logic                  done;
  logic [dout_WIDTH-1:0] dout;
  logic [din1_WIDTH:0]   rout;
  logic                  ovf;
  logic                  dz;

  modport master (
    output start, din0, din1,
    input  ready, done, dout, rout, ovf, dz
  );

  modport slave (
    input  start, din0, din1,
    output ready, done, dout, rout, ovf, dz
  );

endinterface

// File: rtl/myproject_sdiv_step.sv
// One restoring shift-subtract step of an unsigned division (purely combinational).
// Ports: rem = partial remainder (< dvs), dvd_bit = next dividend bit, dvs = divisor;
// rem_next = updated partial remainder, q_bit = quotient bit. Zero latency, no handshake.
module myproject_sdiv_step
  import myproject_arith_pkg::*;
#(
  parameter int W = DIN1_W
) (
  input  logic [W-1:0] rem,
  input  logic         dvd_bit,
  input  logic [W-1:0] dvs,
  output logic [W-1:0] rem_next,
  output logic         q_bit
);

  logic [W:0] trial;

  always_comb begin
    trial    = {rem, dvd_bit};
    q_bit    = (trial >= {1'b0, dvs});
    // When the subtract succeeds the result is below dvs, so the low W bits
    // of the modular difference are exact.
    rem_next = q_bit ? (trial[W-1:0] - dvs) : trial[W-1:0];
  end

endmodule

// File: rtl/myproject_sdiv_26s_13ns_16_seq.sv
// Sequential signed divider: signed din0 / unsigned din1 -> saturated signed quotient + remainder.
// Latency: start taken at edge N gives done during the cycle after edge N+din0_WIDTH+2.
// Backpressure: ready is high only in IDLE; start while busy is dropped (no queuing).
// Ports: ap_clk, ap_rst (sync, active high), bus (slave: start/din0/din1 in; ready/done/dout/rout/ovf/dz out).
module myproject_sdiv_26s_13ns_16_seq
  import myproject_arith_pkg::*;
#(
  parameter int ID         = 1,
  parameter int din0_WIDTH = DIN0_W,
  parameter int din1_WIDTH = DIN1_W,
  parameter int dout_WIDTH = DOUT_W
) (
  input logic ap_clk,
  input logic ap_rst,
  myproject_sdiv_26s_13ns_16_seq_if.slave bus
);

  localparam int CNT_W = $clog2(din0_WIDTH + 1);
  // CALC runs one extra cycle at cnt == LAST_CNT without stepping, which
  // gives the fixed din0_WIDTH+2 latency.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(din0_WIDTH);

  // Largest quotient magnitudes that still fit dout_WIDTH (assumes dout_WIDTH <= din0_WIDTH).
  localparam logic [din0_WIDTH-1:0] POS_LIM = din0_WIDTH'((2 ** (dout_WIDTH - 1)) - 1);
  localparam logic [din0_WIDTH-1:0] NEG_LIM = din0_WIDTH'(2 ** (dout_WIDTH - 1));

  // Package constants cover the default width; other widths use the same bit pattern.
  localparam logic [dout_WIDTH-1:0] SAT_POS = (dout_WIDTH == DOUT_W) ? dout_WIDTH'(QMAX)
                                              : {1'b0, {(dout_WIDTH-1){1'b1}}};
  localparam logic [dout_WIDTH-1:0] SAT_NEG = (dout_WIDTH == DOUT_W) ? dout_WIDTH'(QMIN)
                                              : {1'b1, {(dout_WIDTH-1){1'b0}}};

  sdiv_state_e state, state_nxt;

  logic [din0_WIDTH-1:0] dvd;   // dividend magnitude, shifted out MSB first
  logic [din0_WIDTH-1:0] quo;   // quotient magnitude, shifted in LSB first
  logic [din1_WIDTH-1:0] dvs;
  logic [din1_WIDTH-1:0] rem;
  logic [din1_WIDTH-1:0] rem_nxt;
  logic                  neg;
  logic [CNT_W-1:0]      cnt;
  logic                  q_bit;

  logic ready_c, done_c, accept;

  logic [dout_WIDTH-1:0] dout_fix, dout_q;
  logic [din1_WIDTH:0]   rout_fix, rout_q;
  logic                  ovf_fix, ovf_q;
  logic                  dz_fix, dz_q;

  // ID is an instance tag only.
  logic unused_id;
  assign unused_id = ^ID;

  myproject_sdiv_step #(.W(din1_WIDTH)) u_step (
    .rem      (rem),
    .dvd_bit  (dvd[din0_WIDTH-1]),
    .dvs      (dvs),
    .rem_next (rem_nxt),
    .q_bit    (q_bit)
  );

  always_ff @(posedge ap_clk) begin
    if (ap_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready_c   = 1'b0;
    done_c    = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        ready_c = 1'b1;
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = CALC;
        end
      end
      CALC: if (cnt == LAST_CNT) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: begin
        done_c    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Sign fix-up and saturation of the unsigned result, registered on FIX->DONE.
  always_comb begin
    dz_fix   = (dvs == '0);
    ovf_fix  = 1'b0;
    dout_fix = '0;
    rout_fix = '0;
    if (dz_fix) begin
      ovf_fix  = 1'b1;
      dout_fix = neg ? SAT_NEG : SAT_POS;
    end else if (neg) begin
      rout_fix = -{1'b0, rem};
      if (quo > NEG_LIM) begin
        ovf_fix  = 1'b1;
        dout_fix = SAT_NEG;
      end else begin
        dout_fix = -quo[dout_WIDTH-1:0];
      end
    end else begin
      rout_fix = {1'b0, rem};
      if (quo > POS_LIM) begin
        ovf_fix  = 1'b1;
        dout_fix = SAT_POS;
      end else begin
        dout_fix = quo[dout_WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      dvd    <= '0;
      quo    <= '0;
      dvs    <= '0;
      rem    <= '0;
      neg    <= 1'b0;
      cnt    <= '0;
      dout_q <= '0;
      rout_q <= '0;
      ovf_q  <= 1'b0;
      dz_q   <= 1'b0;
    end else begin
      if (accept) begin
        // Magnitude of the most negative dividend still fits unsigned.
        dvd <= bus.din0[din0_WIDTH-1] ? (-bus.din0) : bus.din0;
        neg <= bus.din0[din0_WIDTH-1];
        dvs <= bus.din1;
        rem <= '0;
        quo <= '0;
        cnt <= '0;
      end else if (state == CALC && cnt != LAST_CNT) begin
        dvd <= {dvd[din0_WIDTH-2:0], 1'b0};
        quo <= {quo[din0_WIDTH-2:0], q_bit};
        rem <= rem_nxt;
        cnt <= cnt + CNT_W'(1);
      end
      if (state == FIX) begin
        dout_q <= dout_fix;
        rout_q <= rout_fix;
        ovf_q  <= ovf_fix;
        dz_q   <= dz_fix;
      end
    end
  end

  assign bus.ready = ready_c;
  assign bus.done  = done_c;
  assign bus.dout  = dout_q;
  assign bus.rout  = rout_q;
  assign bus.ovf   = ovf_q;
  assign bus.dz    = dz_q;

endmodule

// File: tb/tb_myproject_sdiv_26s_13ns_16_seq.sv
// Bench for the sequential signed divider: directed corner cases, busy-start,
// mid-operation reset, and random operands against an integer-arithmetic model.
// Inputs driven on the falling edge, outputs sampled 1 time unit after the rising edge.
module tb_myproject_sdiv_26s_13ns_16_seq;
  import myproject_arith_pkg::*;

  logic ap_clk = 1'b0;
  logic ap_rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [15:0] r_dout;
  logic [13:0] r_rout;
  logic        r_ovf, r_dz;

  myproject_sdiv_26s_13ns_16_seq_if bus ();

  myproject_sdiv_26s_13ns_16_seq dut (
    .ap_clk (ap_clk),
    .ap_rst (ap_rst),
    .bus    (bus)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // C-style integer division with 16-bit saturation.
  function automatic void ref_div(input longint a, input longint b,
                                  output logic [15:0] q, output logic [13:0] r,
                                  output logic o, output logic z);
    longint qq, rr;
    if (b == 0) begin
      z = 1'b1; o = 1'b1; r = '0;
      q = (a >= 0) ? QMAX : QMIN;
    end else begin
      z  = 1'b0;
      qq = a / b;
      rr = a % b;
      r  = 14'(rr);
      if (qq > 32767)       begin o = 1'b1; q = QMAX; end
      else if (qq < -32768) begin o = 1'b1; q = QMIN; end
      else                  begin o = 1'b0; q = 16'(qq); end
    end
  endfunction

  task automatic run_div(input logic [25:0] a, input logic [12:0] b, input string tag);
    logic [15:0] eq;
    logic [13:0] er;
    logic        eo, ez;
    int          lat;
    ref_div(longint'($signed(a)), longint'(b), eq, er, eo, ez);
    @(negedge ap_clk);
    chk({tag, " ready"}, 64'(bus.ready), 64'd1);
    bus.din0  = a;
    bus.din1  = b;
    bus.start = 1'b1;
    @(posedge ap_clk); #1;
    // Operands must have been captured on acceptance.
    bus.start = 1'b0;
    bus.din0  = 26'($urandom);
    bus.din1  = 13'($urandom);
    lat = 0;
    do begin
      @(posedge ap_clk); #1;
      lat++;
    end while (!bus.done && lat < 40);
    chk({tag, " latency"}, 64'(lat), 64'd28);
    chk({tag, " dout"}, 64'(bus.dout), 64'(eq));
    chk({tag, " rout"}, 64'(bus.rout), 64'(er));
    chk({tag, " ovf"},  64'(bus.ovf),  64'(eo));
    chk({tag, " dz"},   64'(bus.dz),   64'(ez));
    r_dout = bus.dout; r_rout = bus.rout; r_ovf = bus.ovf; r_dz = bus.dz;
    @(posedge ap_clk); #1;
    chk({tag, " done pulse"}, 64'(bus.done), 64'd0);
    chk({tag, " dout hold"}, 64'(bus.dout), 64'(eq));
  endtask

  task automatic busy_test();
    int dones = 0;
    int first = -1;
    logic [15:0] q_at_done = '0;
    logic [13:0] r_at_done = '0;
    @(negedge ap_clk);
    bus.din0 = 26'd1000; bus.din1 = 13'd7; bus.start = 1'b1;
    @(posedge ap_clk); #1;
    bus.start = 1'b0;
    for (int c = 1; c <= 45; c++) begin
      @(posedge ap_clk); #1;
      if (bus.done) begin
        dones++;
        if (first < 0) begin
          first = c; q_at_done = bus.dout; r_at_done = bus.rout;
        end
      end
      if (c == 3 || c == 10) begin
        chk($sformatf("busy ready c%0d", c), 64'(bus.ready), 64'd0);
        bus.start = 1'b1; bus.din0 = 26'd999; bus.din1 = 13'd3;
      end else begin
        bus.start = 1'b0;
      end
    end
    chk("busy done count", 64'(dones), 64'd1);
    chk("busy done cycle", 64'(first), 64'd28);
    chk("busy dout", 64'(q_at_done), 64'd142);
    chk("busy rout", 64'(r_at_done), 64'd6);
  endtask

  task automatic reset_test();
    int dones = 0;
    @(negedge ap_clk);
    bus.din0 = 26'd1000; bus.din1 = 13'd7; bus.start = 1'b1;
    @(posedge ap_clk); #1;
    bus.start = 1'b0;
    repeat (12) begin
      @(posedge ap_clk); #1;
      if (bus.done) dones++;
    end
    ap_rst = 1'b1;
    @(posedge ap_clk); #1;
    ap_rst = 1'b0;
    chk("mid-rst ready", 64'(bus.ready), 64'd1);
    chk("mid-rst done",  64'(bus.done),  64'd0);
    chk("mid-rst dout",  64'(bus.dout),  64'd0);
    chk("mid-rst rout",  64'(bus.rout),  64'd0);
    chk("mid-rst ovf",   64'(bus.ovf),   64'd0);
    chk("mid-rst dz",    64'(bus.dz),    64'd0);
    repeat (35) begin
      @(posedge ap_clk); #1;
      if (bus.done) dones++;
    end
    chk("mid-rst no done", 64'(dones), 64'd0);
    run_div(26'd1000, 13'd7, "post-rst 1000/7");
    chk("post-rst dout const", 64'(r_dout), 64'd142);
  endtask

  initial begin
    logic [25:0] a;
    logic [12:0] b;
    ap_rst    = 1'b1;
    bus.start = 1'b0;
    bus.din0  = '0;
    bus.din1  = '0;
    repeat (3) @(posedge ap_clk);
    #1;
    chk("rst ready", 64'(bus.ready), 64'd1);
    chk("rst done",  64'(bus.done),  64'd0);
    chk("rst dout",  64'(bus.dout),  64'd0);
    chk("rst rout",  64'(bus.rout),  64'd0);
    chk("rst ovf",   64'(bus.ovf),   64'd0);
    chk("rst dz",    64'(bus.dz),    64'd0);
    // start during reset must not be taken
    bus.start = 1'b1; bus.din0 = 26'd100; bus.din1 = 13'd3;
    @(posedge ap_clk);
    @(negedge ap_clk);
    ap_rst = 1'b0; bus.start = 1'b0;
    @(posedge ap_clk); #1;
    chk("start in rst ignored", 64'(bus.ready), 64'd1);

    run_div(26'd1000, 13'd7, "1000/7");
    chk("1000/7 const dout", 64'(r_dout), 64'd142);
    chk("1000/7 const rout", 64'(r_rout), 64'd6);
    run_div(-26'sd1000, 13'd7, "-1000/7");
    chk("-1000/7 const dout", 64'(r_dout), 64'h0000_0000_0000_FF72);
    chk("-1000/7 const rout", 64'(r_rout), 64'(14'h3FFA));
    chk("-1000/7 const ovf", 64'(r_ovf), 64'd0);
    run_div(26'd33554431, 13'd1, "max/1");
    chk("max/1 const dout", 64'(r_dout), 64'h7FFF);
    chk("max/1 const ovf", 64'(r_ovf), 64'd1);
    run_div(-26'sd32768, 13'd1, "-32768/1");
    chk("-32768/1 const dout", 64'(r_dout), 64'h8000);
    chk("-32768/1 const ovf", 64'(r_ovf), 64'd0);
    run_div(-26'sd32769, 13'd1, "-32769/1");
    run_div(26'd32767, 13'd1, "32767/1");
    run_div(26'd32768, 13'd1, "32768/1");
    run_div(26'd5, 13'd0, "5/0");
    chk("5/0 const dz", 64'(r_dz), 64'd1);
    chk("5/0 const dout", 64'(r_dout), 64'h7FFF);
    run_div(-26'sd5, 13'd0, "-5/0");
    chk("-5/0 const dout", 64'(r_dout), 64'h8000);
    run_div(26'h2000000, 13'd8191, "min/8191");
    run_div(26'd0, 13'd5, "0/5");
    run_div(-26'sd7, 13'd8191, "-7/8191");

    busy_test();
    reset_test();

    for (int i = 0; i < 40; i++) begin
      if (i % 2 == 0) begin
        a = 26'($urandom_range(0, 400000));
        if ($urandom_range(0, 1) == 1) a = -a;
        b = 13'($urandom_range(1, 8191));
      end else begin
        a = 26'($urandom);
        b = (i % 5 == 1) ? 13'd0 : 13'($urandom);
      end
      run_div(a, b, $sformatf("rand%0d %0d/%0d", i, $signed(a), b));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
